// File: rtl/systolic_seq_pkg.sv
// Shared types and constants for the systolic array sequencer.
// The enum encodes the job phases. flush_len gives the skew drain length of a DIM x DIM array.
package systolic_pkg;

  localparam int DIM_DEF = 4;
  localparam int KW_DEF  = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRELOAD = 3'd1,
    COMPUTE = 3'd2,
    READOUT = 3'd3,
    DONE    = 3'd4
  } seq_state_t;

  // Cycles for the last operand to travel from the array corner to PE(DIM-1, DIM-1).
  function automatic int flush_len(input int dim);
    return 2 * (dim - 1);
  endfunction

endpackage

// File: rtl/systolic_seq_if.sv
// Host/array-side control bundle of the sequencer.
// The master modport is the host side. The slave modport is the sequencer side.
interface systolic_seq_if
  import systolic_pkg::*;
#(
    parameter int DIM = DIM_DEF,
    parameter int KW  = KW_DEF
);

    localparam int RW = (DIM > 1) ? $clog2(DIM) : 1;

    logic          start;
    logic [KW-1:0] k_len;
    logic          preload_zero;
    logic          stall;
    logic          abort;
    logic          busy;
    logic          done;
    logic          mac_en;
    logic [DIM-1:0] mac_wren;
    logic          c_zero;
    logic          feed_valid;
    logic [KW-1:0] feed_k;
    logic          rd_valid;
    logic [RW-1:0] rd_row;

    modport master (
        output start, k_len, preload_zero, stall, abort,
        input  busy, done, mac_en, mac_wren, c_zero, feed_valid, feed_k, rd_valid, rd_row
    );

    modport slave (
        input  start, k_len, preload_zero, stall, abort,
        output busy, done, mac_en, mac_wren, c_zero, feed_valid, feed_k, rd_valid, rd_row
    );

endinterface

// File: rtl/systolic_seq_counter.sv
// Up-counter with synchronous clear, increment enable and a terminal-count compare.
// The terminal value is a run-time input, and the compare uses the full counter width.
module seq_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    input  logic [W-1:0] last_i,
    output logic [W-1:0] count_o,
    output logic         tc_o
);

    logic [W-1:0] count_q;

    // NOTE: sequential state uses non-blocking assignments, so every flop samples the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (inc_i) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == last_i);

endmodule

// File: rtl/systolic_seq.sv
// Job sequencer for a DIM x DIM MAC array. Per job it runs preload, compute (K steps plus the skew flush), and then row readout.
// All outputs are decoded from the registered state and counters, gated by stall.
module systolic_seq
  import systolic_pkg::*;
#(
    parameter int DIM = DIM_DEF,
    parameter int KW  = KW_DEF
) (
    input logic           clk,
    input logic           rst_n,
    systolic_seq_if.slave bus_if
);

    localparam int RW = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int SW = KW + 1;
    localparam logic [SW-1:0] FLUSH    = SW'(flush_len(DIM));
    localparam logic [RW-1:0] ROW_LAST = RW'(DIM - 1);

    seq_state_t    state_q, state_d;
    logic [KW-1:0] k_len_q;
    logic          preload_zero_q;

    logic [RW-1:0] row;
    logic [SW-1:0] step;
    logic [SW-1:0] step_last;
    logic          row_tc, step_tc;
    logic          row_clr, row_inc, step_clr, step_inc;
    logic          feed_in_range;

    // The step counter is one bit wider than k_len, so T = k_len + flush never wraps.
    assign step_last = {1'b0, k_len_q} + FLUSH - SW'(1);

    // NOTE: every signal driven here gets a default first, so no path infers a latch.
    always_comb begin
        state_d  = state_q;
        row_clr  = 1'b0;
        row_inc  = 1'b0;
        step_clr = 1'b0;
        step_inc = 1'b0;
        case (state_q)
            IDLE: begin
                row_clr  = 1'b1;
                step_clr = 1'b1;
                if (bus_if.start && !bus_if.abort) state_d = PRELOAD;
            end
            PRELOAD: if (!bus_if.stall) begin
                if (row_tc) begin
                    row_clr = 1'b1;
                    state_d = COMPUTE;
                end else begin
                    row_inc = 1'b1;
                end
            end
            COMPUTE: if (!bus_if.stall) begin
                if (step_tc) begin
                    step_clr = 1'b1;
                    state_d  = READOUT;
                end else begin
                    step_inc = 1'b1;
                end
            end
            READOUT: if (!bus_if.stall) begin
                if (row_tc) begin
                    row_clr = 1'b1;
                    state_d = DONE;
                end else begin
                    row_inc = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A kill from any active phase overrides stall and counting alike.
        if (state_q != IDLE && bus_if.abort) begin
            state_d  = IDLE;
            row_clr  = 1'b1;
            step_clr = 1'b1;
            row_inc  = 1'b0;
            step_inc = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            k_len_q        <= '0;
            preload_zero_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && bus_if.start && !bus_if.abort) begin
                k_len_q        <= bus_if.k_len;
                preload_zero_q <= bus_if.preload_zero;
            end
        end
    end

    seq_counter #(.W(RW)) u_row_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (row_clr),
        .inc_i   (row_inc),
        .last_i  (ROW_LAST),
        .count_o (row),
        .tc_o    (row_tc)
    );

    seq_counter #(.W(SW)) u_step_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (step_clr),
        .inc_i   (step_inc),
        .last_i  (step_last),
        .count_o (step),
        .tc_o    (step_tc)
    );

    assign feed_in_range = (step < {1'b0, k_len_q});

    assign bus_if.busy       = (state_q == PRELOAD) || (state_q == COMPUTE) || (state_q == READOUT);
    assign bus_if.done       = (state_q == DONE);
    assign bus_if.mac_en     = (state_q == COMPUTE) && !bus_if.stall;
    assign bus_if.mac_wren   = (state_q == PRELOAD && !bus_if.stall) ? (DIM'(1) << row) : '0;
    assign bus_if.c_zero     = (state_q == PRELOAD) && preload_zero_q;
    assign bus_if.feed_valid = (state_q == COMPUTE) && !bus_if.stall && feed_in_range;
    // The read index holds through a stall; only the valid qualifier drops.
    assign bus_if.feed_k     = (state_q == COMPUTE && feed_in_range) ? step[KW-1:0] : '0;
    assign bus_if.rd_valid   = (state_q == READOUT) && !bus_if.stall;
    assign bus_if.rd_row     = (state_q == READOUT) ? row : '0;

endmodule
